// File: rtl/fc_neuron_stream.sv
// fc_neuron_stream: serial multiply-accumulate fully-connected layer with bias, saturation and optional ReLU
module fc_neuron_stream #(
    parameter int N_IN  = 3136,
    parameter int N_OUT = 1,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    parameter int B_W   = 9,
    parameter int ACC_W = 52,
    parameter int OUT_W = 38,
    parameter int RELU  = 0,
    parameter int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_OUT*B_W-1:0]   bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic [N_OUT*W_W-1:0]   w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic [N_OUT-1:0]       ovf,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [N_OUT*B_W-1:0]    bias_r;
    logic signed [ACC_W-1:0] acc  [N_OUT];
    logic signed [ACC_W-1:0] prod [N_OUT];
    logic signed [ACC_W-1:0] sum  [N_OUT];
    logic [N_OUT-1:0]        clip;
    logic [N_OUT*OUT_W-1:0]  res;

    // Per-lane datapath: exact product, bias addition, saturation to OUT_W, optional ReLU.
    // ACC_W must exceed OUT_W, B_W and IN_W+W_W for the sign extensions below.
    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        logic [W_W-1:0]                w;
        logic [B_W-1:0]                b;
        logic signed [IN_W+W_W-1:0]    xa, wa, p;
        logic [ACC_W-OUT_W:0]          top;
        logic [OUT_W-1:0]              sat;
        assign w       = w_data[k*W_W +: W_W];
        assign b       = bias_r[k*B_W +: B_W];
        assign xa      = {{W_W{in_data[IN_W-1]}}, in_data};
        assign wa      = {{IN_W{w[W_W-1]}}, w};
        assign p       = xa * wa;
        assign prod[k] = {{(ACC_W-IN_W-W_W){p[IN_W+W_W-1]}}, p};
        assign sum[k]  = acc[k] + {{(ACC_W-B_W){b[B_W-1]}}, b};
        // Value fits iff every bit from the OUT_W sign position upward agrees.
        assign top     = sum[k][ACC_W-1:OUT_W-1];
        assign clip[k] = !(&top || ~|top);
        assign sat     = clip[k] ? {sum[k][ACC_W-1], {(OUT_W-1){~sum[k][ACC_W-1]}}} : sum[k][OUT_W-1:0];
        assign res[k*OUT_W +: OUT_W] = (RELU != 0 && sat[OUT_W-1]) ? '0 : sat;
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE:    if (start) state_nx = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CNT_W'(N_IN - 1)) state_nx = BIAS;
            end
            BIAS:    state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, accumulators and the registered result held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bias_r   <= '0;
            out_data <= '0;
            ovf      <= '0;
            done     <= 1'b0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
        end else begin
            state <= state_nx;
            done  <= out_valid && out_ready;
            if (state == IDLE && start) begin
                bias_r <= bias;
                cnt    <= '0;
                for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            end
            if (in_ready && in_valid) begin
                cnt <= cnt + CNT_W'(1);
                for (int k = 0; k < N_OUT; k++) acc[k] <= acc[k] + prod[k];
            end
            if (state == BIAS) begin
                out_data <= res;
                ovf      <= clip;
                for (int k = 0; k < N_OUT; k++) acc[k] <= sum[k];
            end
        end
    end
endmodule

// File: tb/tb_fc_neuron_stream.sv
// tb_fc_neuron_stream: randomized and directed checks of fc_neuron_stream against a dot-product model
module tb_fc_neuron_stream;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int IN_W  = 8;
    localparam int W_W   = 6;
    localparam int B_W   = 6;
    localparam int ACC_W = 20;
    localparam int OUT_W = 8;

    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [N_OUT*B_W-1:0]   bias = '0;
    logic [IN_W-1:0]        in_data = '0;
    logic [N_OUT*W_W-1:0]   w_data = '0;
    logic in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1, done0, done1;
    logic [N_OUT*OUT_W-1:0] out_data0, out_data1;
    logic [N_OUT-1:0]       ovf0, ovf1;

    int passes = 0, total = 0, cyc = 0;
    int xs [N_IN];
    int ws [N_OUT][N_IN];
    int bs [N_OUT];
    logic [N_OUT*OUT_W-1:0] q0 [$];
    logic [N_OUT*OUT_W-1:0] q1 [$];
    logic [N_OUT-1:0]       qo [$];
    bit hs_prev = 0;

    fc_neuron_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W), .B_W(B_W),
                       .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .w_data(w_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .ovf(ovf0), .busy(busy0), .done(done0));

    fc_neuron_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W), .B_W(B_W),
                       .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .w_data(w_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .ovf(ovf1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain dot product plus bias, clamp to OUT_W range, optional ReLU.
    function automatic void model(input bit relu, output logic [N_OUT*OUT_W-1:0] d, output logic [N_OUT-1:0] o);
        longint s, lo, hi;
        lo = -(longint'(1) <<< (OUT_W - 1));
        hi = -lo - 1;
        d = '0;
        o = '0;
        for (int k = 0; k < N_OUT; k++) begin
            s = bs[k];
            for (int i = 0; i < N_IN; i++) s += longint'(xs[i]) * longint'(ws[k][i]);
            o[k] = (s > hi) || (s < lo);
            if (s > hi) s = hi;
            else if (s < lo) s = lo;
            if (relu && s < 0) s = 0;
            d[k*OUT_W +: OUT_W] = OUT_W'(s);
        end
    endfunction

    function automatic int lane(input logic [N_OUT*OUT_W-1:0] d, input int k);
        logic signed [OUT_W-1:0] v;
        v = d[k*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    task automatic set_beat(input int i);
        in_data = IN_W'(xs[i]);
        for (int k = 0; k < N_OUT; k++) w_data[k*W_W +: W_W] = W_W'(ws[k][i]);
    endtask

    task automatic load(input int x0, x1, x2, x3, input int a0, a1, a2, a3,
                        input int b0, b1, b2, b3, input int c0, c1);
        xs = '{x0, x1, x2, x3};
        ws[0] = '{a0, a1, a2, a3};
        ws[1] = '{b0, b1, b2, b3};
        bs = '{c0, c1};
    endtask

    // One full inference: start, N_IN beats with optional gaps, optional output backpressure.
    task automatic run(input int gap, input int hold, input bit poke, input bit junk, output int ov_cyc);
        logic [N_OUT*OUT_W-1:0] e0, e1;
        logic [N_OUT-1:0] eo, eo1;
        int c0, t;
        model(0, e0, eo);
        model(1, e1, eo1);
        for (int k = 0; k < N_OUT; k++) bias[k*B_W +: B_W] = B_W'(bs[k]);
        start = 1;
        out_ready = (hold == 0);
        if (junk) begin
            in_valid = 1;
            in_data = IN_W'($urandom);
            w_data = (N_OUT*W_W)'($urandom);
        end
        c0 = cyc;
        @(posedge clk); #1;
        start = 0;
        in_valid = 0;
        bias = (N_OUT*B_W)'($urandom);
        for (int i = 0; i < N_IN; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = poke;
                @(posedge clk); #1;
                start = 0;
            end
            set_beat(i);
            in_valid = 1;
            t = 0;
            while (!in_ready0 && t < 50) begin @(posedge clk); #1; t++; end
            chk(in_ready0 == 1'b1, "beat_accept", in_ready0, 1);
            @(posedge clk); #1;
            in_valid = 0;
        end
        q0.push_back(e0);
        q1.push_back(e1);
        qo.push_back(eo);
        t = 0;
        while (!out_valid0 && t < 50) begin @(posedge clk); #1; t++; end
        chk(out_valid0 == 1'b1, "out_valid_wait", out_valid0, 1);
        ov_cyc = cyc;
        if (gap == 0) chk(cyc - c0 == N_IN + 2, "latency", cyc - c0, N_IN + 2);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!done0 && t < 50);
        chk(done0 == 1'b1, "done_wait", done0, 1);
        chk(out_valid0 == 1'b0, "valid_after_done", out_valid0, 0);
    endtask

    // Cycle-by-cycle comparison of both DUTs against the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hs_prev = 0;
                continue;
            end
            chk(busy0 == busy1 && in_ready0 == in_ready1 && out_valid0 == out_valid1 && done0 == done1,
                "lockstep", {busy1, in_ready1, out_valid1, done1}, {busy0, in_ready0, out_valid0, done0});
            chk(done0 == hs_prev, "done_pulse", done0, hs_prev);
            if (!busy0) chk(!in_ready0 && !out_valid0, "idle_quiet", {in_ready0, out_valid0}, 0);
            if (out_valid0) begin
                if (q0.size() == 0) chk(0, "unexpected_out", out_data0, 0);
                else begin
                    chk(out_data0 == q0[0], "out_norelu", out_data0, q0[0]);
                    chk(out_data1 == q1[0], "out_relu", out_data1, q1[0]);
                    chk(ovf0 == qo[0] && ovf1 == qo[0], "ovf", {ovf1, ovf0}, {qo[0], qo[0]});
                    if (out_ready) begin
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                        void'(qo.pop_front());
                    end
                end
            end
            hs_prev = out_valid0 && out_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end

    initial begin
        logic [N_OUT*OUT_W-1:0] e;
        logic [N_OUT-1:0] o;
        int ov1, ov2, ax, aw;
        repeat (3) @(posedge clk);
        #1;
        chk(!in_ready0 && !out_valid0 && !busy0 && !done0, "reset_ctrl", {in_ready0, out_valid0, busy0, done0}, 0);
        chk(out_data0 == '0 && out_data1 == '0, "reset_data", out_data0, 0);
        chk(ovf0 == '0 && ovf1 == '0, "reset_ovf", ovf0, 0);
        rst = 0;
        @(posedge clk); #1;

        // Model pins from hand-computed scenarios.
        load(1, 2, 3, 4, 1, -1, 2, 3, 0, 0, 0, 0, 5, 0);
        model(0, e, o);
        chk(lane(e, 0) == 22 && o == 2'b00, "model_s1", lane(e, 0), 22);
        load(10, 10, 10, 10, 2, 2, 2, 2, -3, -3, -3, -3, 0, 1);
        model(0, e, o);
        chk(lane(e, 0) == 80 && lane(e, 1) == -119, "model_s2", lane(e, 1), -119);
        model(1, e, o);
        chk(lane(e, 0) == 80 && lane(e, 1) == 0, "model_s2_relu", lane(e, 1), 0);
        load(100, 100, 0, 0, 2, 2, 0, 0, -2, -2, 0, 0, 0, 0);
        model(0, e, o);
        chk(lane(e, 0) == 127 && lane(e, 1) == -128 && o == 2'b11, "model_s3", lane(e, 1), -128);

        // Directed scenarios on the DUTs.
        load(1, 2, 3, 4, 1, -1, 2, 3, 0, 0, 0, 0, 5, 0);
        run(0, 0, 0, 0, ov1);
        load(10, 10, 10, 10, 2, 2, 2, 2, -3, -3, -3, -3, 0, 1);
        run(0, 0, 0, 0, ov1);
        load(100, 100, 0, 0, 2, 2, 0, 0, -2, -2, 0, 0, 0, 0);
        run(0, 0, 0, 0, ov1);
        load(1, 2, 3, 4, 1, -1, 2, 3, 0, 0, 0, 0, 5, 0);
        run(3, 5, 1, 0, ov1);

        // Abort after two beats, then a clean rerun.
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 2; i++) begin
            set_beat(i);
            in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk(!in_ready0 && !out_valid0 && !busy0, "abort", {in_ready0, out_valid0, busy0}, 0);
        run(0, 0, 0, 0, ov1);

        // Back-to-back with start in the done cycle and junk in_valid while idle.
        run(0, 0, 0, 1, ov1);
        load(10, 10, 10, 10, 2, 2, 2, 2, -3, -3, -3, -3, 0, 1);
        run(0, 0, 0, 1, ov2);
        chk(ov2 - ov1 == N_IN + 3, "back_to_back", ov2 - ov1, N_IN + 3);

        // Randomized inferences.
        for (int r = 0; r < 24; r++) begin
            ax = ($urandom_range(0, 1) != 0) ? 127 : 15;
            aw = ($urandom_range(0, 1) != 0) ? 31 : 7;
            for (int i = 0; i < N_IN; i++) begin
                xs[i] = int'($urandom_range(0, 2 * ax)) - ax;
                for (int k = 0; k < N_OUT; k++) ws[k][i] = int'($urandom_range(0, 2 * aw)) - aw;
            end
            for (int k = 0; k < N_OUT; k++) bs[k] = int'($urandom_range(0, 62)) - 31;
            run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ov1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk(q0.size() == 0, "queue_drained", q0.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/fc_neuron_stream.md
Name: fc_neuron_stream

Overview:
- Parametrised fully-connected layer engine. Computes N_OUT dot products over an N_IN-element input vector, streamed one element per beat, plus per-neuron bias.
- Optional ReLU and saturating output narrowing.
- Replaces single-neuron, single-cycle FC stages with a serial multiply-accumulate (MAC) engine that has valid/ready handshakes.
- Sits between the flatten/pool output stream and the classifier/argmax stage.

Parameters:
N_IN, 3136, input vector length (beats per inference), >=1
N_OUT, 1, neurons computed in parallel (lanes sharing each input element)
IN_W, 30, signed input element width
W_W, 9, signed weight width
B_W, 9, signed bias width
ACC_W, 52, signed accumulator width; must be >= IN_W+W_W+clog2(N_IN)+1
OUT_W, 38, signed output width per lane
RELU, 0, 1 = clamp negative results to 0 after saturation
CNT_W, clog2(N_IN), element counter width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin inference; sampled only in IDLE
bias  in  N_OUT*B_W  packed signed biases, lane k at [k*B_W +: B_W]; captured on accepted start
in_valid  in  1  input element valid
in_ready  out  1  engine accepts element
in_data  in  IN_W  signed input element
w_data  in  N_OUT*W_W  packed signed weights for the current element, qualified by in_valid
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
out_data  out  N_OUT*OUT_W  packed signed results, lane k at [k*OUT_W +: OUT_W]
ovf  out  N_OUT  per-lane saturation flag, valid with out_valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the cycle after the output handshake

Behaviour:
- Reset: state = IDLE; counter, accumulators and bias registers = 0; in_ready = 0, out_valid = 0, out_data = 0, ovf = 0, busy = 0, done = 0.
- A reset asserted in any state aborts the operation in the same edge. No partial result is ever presented.
- FSM states: IDLE, ACCUM, BIAS, OUT.
- IDLE:
  - start = 1 -> capture bias, clear accumulators and counter, go to ACCUM.
  - in_ready = 0; in_valid is ignored.
- ACCUM:
  - in_ready = 1.
  - Each accepted beat (in_valid & in_ready): acc[k] += sext(in_data * w_data[k]), full-precision product of IN_W+W_W bits, sign-extended to ACC_W; counter increments.
  - Beat with counter == N_IN-1 -> go to BIAS.
  - Gaps (in_valid = 0) hold all state.
  - in_ready is deasserted in the cycle after the last beat. The last beat is never double-counted.
- BIAS: exactly one cycle. acc[k] += sext(bias[k]); go to OUT.
- OUT:
  - out_valid = 1.
  - out_data[k] = acc[k] saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - ovf[k] = 1 iff clipping occurred.
  - If RELU = 1, negative saturated values become 0 (ovf is unaffected).
  - out_data and ovf are registered and stable while out_valid = 1 and out_ready = 0.
  - Handshake (out_valid & out_ready) -> IDLE, out_valid = 0 next cycle, done = 1 for that one cycle.
- start asserted outside IDLE is ignored. start in the same cycle that done is high is accepted (state is IDLE).
- Latency with no input gaps: start at cycle 0 gives first in_ready at 1, last beat at N_IN, out_valid at N_IN+2.
- Throughput: one inference per N_IN+3 cycles when out_ready is held high.
- Accumulator arithmetic is two's complement at ACC_W. With the ACC_W constraint met, no internal wrap is possible.
- N_IN = 1: a single accepted beat goes directly to BIAS.

Test Plan:
1. N_IN=4, N_OUT=1, RELU=0; in = {1,2,3,4}, w = {1,-1,2,3}, bias = 5 -> out_data = 22, ovf = 0; out_valid at cycle 6 after start; done pulses for one cycle.
2. N_OUT=2, N_IN=4; lane weights {2,2,2,2} and {-3,-3,-3,-3}, in = {10,10,10,10}, bias = {0,1}; RELU=1 -> out = {80,0}; RELU=0 -> out = {80,-119}.
3. Saturation: OUT_W=8, N_IN=2; in = {100,100}, w = {2,2}, bias = 0 -> out = 127, ovf = 1. Same stimulus with w = {-2,-2} -> out = -128, ovf = 1.
4. Backpressure and gaps: insert 3 idle cycles between beats and hold out_ready = 0 for 5 cycles -> result matches scenario 1; out_data stays stable; a start pulse during ACCUM is ignored; done pulses once.
5. Reset mid-operation: rst after 2 of 4 beats -> in_ready, out_valid, busy all 0 next cycle. A new inference with scenario 1 stimulus then yields 22, with no residue from the aborted run.
6. Back-to-back: start asserted in the done cycle with out_ready tied high -> second result valid exactly N_IN+3 cycles after the first; in_valid during IDLE is never consumed.
